// File: rtl/snax_hwpe_reg_pkg.sv
// Shared constants for the SNAX HWPE register slave: word-index register map,
// job FSM state encoding and default ID width.
package snax_hwpe_reg_pkg;

  localparam int unsigned DefaultIdWidth    = 5;
  localparam int unsigned DefaultNumCfgRegs = 8;

  // Word indices (byte address >> 2)
  localparam logic [29:0] IdxTrigger = 30'd0;
  localparam logic [29:0] IdxStatus  = 30'd1;
  localparam logic [29:0] IdxJobCnt  = 30'd2;
  localparam logic [29:0] IdxPerfCyc = 30'd3;
  localparam logic [29:0] IdxCfgBase = 30'd4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } job_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral register bus: one-cycle grant, response exactly one cycle later.
// Handshake: a request is taken when req && gnt; r_valid then pulses once with r_id/r_data.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = snax_hwpe_reg_pkg::DefaultIdWidth
) ();

  logic                req;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                gnt;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_valid, r_data, r_id
  );

endinterface

// File: rtl/snax_hwpe_job_fsm.sv
// IDLE/RUN job sequencer: starts on a TRIGGER write in IDLE, ends on done_i in RUN.
// start_o/evt_o are registered one-cycle pulses following the respective transition.
module snax_hwpe_job_fsm
  import snax_hwpe_reg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trigger_i,
  input  logic       done_i,
  output logic       enter_run_o,
  output logic       done_acc_o,
  output logic       start_o,
  output logic       evt_o,
  output job_state_e state_o
);

  job_state_e state_q, state_d;
  logic       start_q, evt_q;

  always_comb begin
    state_d     = state_q;
    enter_run_o = 1'b0;
    done_acc_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (trigger_i) begin
          state_d     = StRun;
          enter_run_o = 1'b1;
        end
      end
      StRun: begin
        // A TRIGGER write landing here, even with done_i, is deliberately dropped.
        if (done_i) begin
          state_d    = StIdle;
          done_acc_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= enter_run_o;
      evt_q   <= done_acc_o;
    end
  end

  assign start_o = start_q;
  assign evt_o   = evt_q;
  assign state_o = state_q;

endmodule

// File: rtl/snax_hwpe_reg_slave.sv
// HWPE control register slave: job trigger/status, job counter and CFG registers.
// Define SNAX_HWPE_PERF_CNT_EN to build in the saturating PERF_CYC run-cycle counter.
module snax_hwpe_reg_slave
  import snax_hwpe_reg_pkg::*;
#(
  parameter int unsigned NumCfgRegs = DefaultNumCfgRegs,
  parameter int unsigned IdWidth    = DefaultIdWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  hwpe_ctrl_intf_periph.slave          periph,
  output logic [NumCfgRegs-1:0][31:0]  cfg_o,
  output logic                         start_o,
  input  logic                         done_i,
  output logic                         busy_o,
  output logic                         evt_o
);

  logic [29:0] idx;
  logic        unused_add_lsb;
  logic        wr_en, rd_en, trigger;
  logic        enter_run, done_acc;
  job_state_e  job_state;

  assign idx            = periph.add[31:2];
  assign unused_add_lsb = ^periph.add[1:0];
  assign wr_en          = periph.req & ~periph.wen;
  assign rd_en          = periph.req & periph.wen;
  assign trigger        = wr_en && (idx == IdxTrigger) && (|periph.be);

  snax_hwpe_job_fsm i_job_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .trigger_i   (trigger),
    .done_i      (done_i),
    .enter_run_o (enter_run),
    .done_acc_o  (done_acc),
    .start_o     (start_o),
    .evt_o       (evt_o),
    .state_o     (job_state)
  );

  assign busy_o = (job_state == StRun);

  logic [NumCfgRegs-1:0][31:0] cfg_q, cfg_d;
  logic [31:0]                 job_cnt_q, job_cnt_d;
  logic [31:0]                 perf_cyc;
  logic [31:0]                 rd_data;
  logic                        r_valid_q;
  logic [31:0]                 r_data_q;
  logic [IdWidth-1:0]          r_id_q;

  // CFG is frozen for the whole job so the engine sees a stable configuration.
  always_comb begin
    cfg_d = cfg_q;
    if (wr_en && !busy_o) begin
      for (int unsigned k = 0; k < NumCfgRegs; k++) begin
        if (idx == IdxCfgBase + 30'(k)) cfg_d[k] = merge_bytes(cfg_q[k], periph.data, periph.be);
      end
    end
  end

  assign job_cnt_d = done_acc ? job_cnt_q + 32'd1 : job_cnt_q;

`ifdef SNAX_HWPE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (enter_run) begin
      perf_d = '0;
    end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cyc = perf_q;
`else
  logic unused_enter_run;
  assign unused_enter_run = enter_run;
  assign perf_cyc         = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (idx)
      IdxStatus:  rd_data = {31'b0, busy_o};
      IdxJobCnt:  rd_data = job_cnt_q;
      IdxPerfCyc: rd_data = perf_cyc;
      default:    rd_data = '0;
    endcase
    for (int unsigned k = 0; k < NumCfgRegs; k++) begin
      if (idx == IdxCfgBase + 30'(k)) rd_data = cfg_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q     <= '0;
      job_cnt_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
    end else begin
      cfg_q     <= cfg_d;
      job_cnt_q <= job_cnt_d;
      r_valid_q <= periph.req;
      r_data_q  <= rd_en ? rd_data : '0;
      r_id_q    <= periph.req ? periph.id : '0;
    end
  end

  assign periph.gnt     = periph.req;
  assign periph.r_valid = r_valid_q;
  assign periph.r_data  = r_data_q;
  assign periph.r_id    = r_id_q;
  assign cfg_o          = cfg_q;

endmodule

// File: tb/tb_snax_hwpe_reg_slave.sv
// Self-checking bench for snax_hwpe_reg_slave: directed job scenarios plus random
// bus traffic against a transaction-level register/job model.
module tb_snax_hwpe_reg_slave;

  localparam int NCFG = 8;
  localparam int IDW  = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  done = 1'b0;
  logic [NCFG-1:0][31:0] cfg;
  logic                  start, busy, evt;

  hwpe_ctrl_intf_periph #(.ID_WIDTH(IDW)) periph_if ();

  snax_hwpe_reg_slave #(.NumCfgRegs(NCFG), .IdWidth(IDW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .periph  (periph_if),
    .cfg_o   (cfg),
    .start_o (start),
    .done_i  (done),
    .busy_o  (busy),
    .evt_o   (evt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  logic [IDW+31:0] exp_q[$];
  logic [31:0]     last_rdata;
  logic [IDW-1:0]  last_rid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy;
  logic [31:0] m_cfg[NCFG];
  logic [31:0] m_job_cnt;
  logic [31:0] m_perf;
  int          cyc = 0;
  int          m_run_start = 0;

  task automatic model_reset();
    m_busy    = 1'b0;
    m_job_cnt = '0;
    m_perf    = '0;
    for (int k = 0; k < NCFG; k++) m_cfg[k] = '0;
    exp_q.delete();
  endtask

  // Run-cycle count: cycles spent busy so far, or the length of the last job.
  function automatic logic [31:0] perf_now();
`ifdef SNAX_HWPE_PERF_CNT_EN
    if (m_busy) return 32'(cyc - m_run_start);
    return m_perf;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input int widx);
    if (widx == 1) return {31'b0, m_busy};
    if (widx == 2) return m_job_cnt;
    if (widx == 3) return perf_now();
    if (widx >= 4 && widx < 4 + NCFG) return m_cfg[widx-4];
    return 32'h0;
  endfunction

  // ---------------- driver ----------------
  task automatic do_cycle(input logic req, input logic wen, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data,
                          input logic [IDW-1:0] id, input logic dn);
    int              widx;
    logic            b0, trig, exp_start, exp_evt;
    logic [IDW+31:0] e;
    @(negedge clk);
    periph_if.req  = req;
    periph_if.wen  = wen;
    periph_if.add  = addr;
    periph_if.be   = be;
    periph_if.data = data;
    periph_if.id   = id;
    done           = dn;
    #1;
    check("gnt", {31'b0, periph_if.gnt}, {31'b0, req});
    widx = int'(addr[31:2]);
    b0   = m_busy;
    if (req) exp_q.push_back({id, wen ? model_read(widx) : 32'h0});
    trig = req && !wen && (widx == 0) && (be != 4'h0);
    if (req && !wen && !b0 && widx >= 4 && widx < 4 + NCFG) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_cfg[widx-4][8*b +: 8] = data[8*b +: 8];
      end
    end
    exp_start = trig && !b0;
    exp_evt   = dn && b0;
    if (exp_start) begin
      m_busy      = 1'b1;
      m_run_start = cyc + 1;
    end
    if (exp_evt) begin
      m_busy    = 1'b0;
      m_job_cnt = m_job_cnt + 32'd1;
      m_perf    = 32'(cyc - m_run_start + 1);
    end
    cyc++;
    @(posedge clk);
    #1;
    check("r_valid", {31'b0, periph_if.r_valid}, {31'b0, req});
    if (req) begin
      e = exp_q.pop_front();
      check("r_id", {27'b0, periph_if.r_id}, {27'b0, e[IDW+31:32]});
      check("r_data", periph_if.r_data, e[31:0]);
    end
    last_rdata = periph_if.r_data;
    last_rid   = periph_if.r_id;
    if (start === 1'b1) n_start++;
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("start", {31'b0, start}, {31'b0, exp_start});
    check("evt", {31'b0, evt}, {31'b0, exp_evt});
    for (int k = 0; k < NCFG; k++) check($sformatf("cfg%0d", k), cfg[k], m_cfg[k]);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                    input logic [IDW-1:0] id);
    do_cycle(1'b1, 1'b0, addr, be, data, id, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [IDW-1:0] id);
    do_cycle(1'b1, 1'b1, addr, 4'h0, 32'h0, id, 1'b0);
  endtask

  task automatic idle(input logic dn);
    do_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, '0, dn);
  endtask

  task automatic drive_idle();
    periph_if.req  = 1'b0;
    periph_if.wen  = 1'b0;
    periph_if.add  = '0;
    periph_if.be   = '0;
    periph_if.data = '0;
    periph_if.id   = '0;
    done           = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_r_valid", {31'b0, periph_if.r_valid}, 32'h0);
    check("rst_r_data", periph_if.r_data, 32'h0);
    check("rst_r_id", {27'b0, periph_if.r_id}, 32'h0);
    check("rst_start", {31'b0, start}, 32'h0);
    check("rst_evt", {31'b0, evt}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    for (int k = 0; k < NCFG; k++) check($sformatf("rst_cfg%0d", k), cfg[k], 32'h0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int unsigned r;
    logic [31:0] a;
    drive_idle();
    model_reset();
    apply_reset();
    rd(32'h08, 5'd0);
    check("jobcnt_after_reset", last_rdata, 32'h0);

    // CFG write/read
    wr(32'h10, 32'hA5A5_A5A5, 4'hF, 5'd1);
    rd(32'h10, 5'd2);
    check("cfg_readback", last_rdata, 32'hA5A5_A5A5);
    check("cfg_o0", cfg[0], 32'hA5A5_A5A5);

    // Byte enables
    apply_reset();
    wr(32'h14, 32'h1122_3344, 4'h5, 5'd3);
    rd(32'h14, 5'd4);
    check("byte_en", last_rdata, 32'h0022_0044);

    // Full job: 10 RUN cycles, done in the last one
    s0 = n_start;
    wr(32'h00, 32'h1, 4'hF, 5'd5);
    repeat (9) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    check("job_start_once", 32'(n_start - s0), 32'd1);
    rd(32'h08, 5'd6);
    check("job_cnt_1", last_rdata, 32'd1);
    rd(32'h0C, 5'd7);
`ifdef SNAX_HWPE_PERF_CNT_EN
    check("perf_cyc", last_rdata, 32'd10);
`else
    check("perf_cyc", last_rdata, 32'd0);
`endif

    // RUN-phase blocking
    s0 = n_start;
    wr(32'h00, 32'h1, 4'h1, 5'd8);
    wr(32'h10, 32'hFFFF_FFFF, 4'hF, 5'd9);
    wr(32'h00, 32'h1, 4'hF, 5'd10);
    rd(32'h10, 5'd11);
    check("run_cfg_blocked", last_rdata, 32'h0);
    check("run_rid", {27'b0, last_rid}, 32'd11);
    idle(1'b1);
    check("run_single_start", 32'(n_start - s0), 32'd1);

    // TRIGGER in the same cycle as done
    s0 = n_start;
    wr(32'h00, 32'h1, 4'hF, 5'd12);
    idle(1'b0);
    do_cycle(1'b1, 1'b0, 32'h00, 4'hF, 32'h1, 5'd13, 1'b1);
    idle(1'b0);
    check("simul_idle", {31'b0, busy}, 32'h0);
    check("simul_one_start", 32'(n_start - s0), 32'd1);
    rd(32'h08, 5'd14);
    check("simul_jobcnt", last_rdata, 32'd3);

    // JOB_CNT wrap
    @(negedge clk);
    force dut.job_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.job_cnt_q;
    m_job_cnt = 32'hFFFF_FFFF;
    rd(32'h08, 5'd15);
    check("jobcnt_forced", last_rdata, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1, 4'hF, 5'd16);
    idle(1'b1);
    rd(32'h08, 5'd17);
    check("jobcnt_wrap", last_rdata, 32'h0);

    // Back-to-back reads
    rd(32'h04, 5'd3);
    check("b2b_id3", {27'b0, last_rid}, 32'd3);
    rd(32'h10, 5'd4);
    check("b2b_id4", {27'b0, last_rid}, 32'd4);
    rd(32'h40, 5'd5);
    check("b2b_id5", {27'b0, last_rid}, 32'd5);

    // Reset while running with a request in its grant cycle
    wr(32'h00, 32'h1, 4'hF, 5'd18);
    @(negedge clk);
    periph_if.req = 1'b1;
    periph_if.wen = 1'b1;
    periph_if.add = 32'h04;
    periph_if.id  = 5'd7;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_run_no_resp", {31'b0, periph_if.r_valid}, 32'h0);
    check("rst_run_idle", {31'b0, busy}, 32'h0);
    @(negedge clk);
    drive_idle();
    model_reset();
    rst_n = 1'b1;
    rd(32'h04, 5'd19);
    check("rst_run_status", last_rdata, 32'h0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      a = (r == 15) ? 32'h1000_0000 : {r[29:0], 2'b00};
      a[1:0] = 2'($urandom_range(0, 3));
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
               4'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, m_busy ? 5 : 15) == 0));
    end
    idle(1'b0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snax_hwpe_reg_slave.md
SNAX_HWPE_REG_SLAVE -- requirements
Module: snax_hwpe_reg_slave

Interface
REQ-001 SHALL have parameter NumCfgRegs, default 8, meaning the number of 32-bit job-configuration registers exposed to the engine.
REQ-002 SHALL have parameter IdWidth, default 5, meaning the width of the periph transaction ID.
REQ-003 SHALL have port clk_i, input, 1, the single clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port periph, hwpe_ctrl_intf_periph.slave: req, add[31:0], wen (1=read, 0=write), be[3:0], data[31:0], id in; gnt, r_valid, r_data[31:0], r_id out.
REQ-006 SHALL have port cfg_o, output, NumCfgRegs x 32, the configuration register contents.
REQ-007 SHALL have port start_o, output, 1, a one-cycle job-start pulse.
REQ-008 SHALL have port done_i, input, 1, a one-cycle job-complete pulse from the engine.
REQ-009 SHALL have port busy_o, output, 1, high while a job runs.
REQ-010 SHALL have port evt_o, output, 1, a one-cycle pulse the cycle after done_i is accepted.

Function
REQ-011 SHALL assert gnt combinationally equal to req; every request is granted the cycle it is presented.
REQ-012 SHALL decode the word index as add[31:2]; map: 0x00 TRIGGER, 0x04 STATUS, 0x08 JOB_CNT, 0x0C PERF_CYC, 0x10+4k CFG[k] for k<NumCfgRegs.
REQ-013 SHALL assert r_valid exactly one cycle after every granted request, read or write, with r_id equal to the granted id.
REQ-014 SHALL drive r_data for reads from the register value sampled in the grant cycle; for writes and unmapped addresses, r_data SHALL be 0.
REQ-015 SHALL apply writes with per-byte enables: byte b of the target is updated only when be[b]=1.
REQ-016 SHALL drop writes to CFG registers while busy_o=1, still granting and responding.
REQ-017 SHALL implement FSM IDLE/RUN: IDLE->RUN on any granted write to TRIGGER with be!=0; RUN->IDLE on done_i.
REQ-018 SHALL pulse start_o in the cycle after the IDLE->RUN transition; busy_o=1 exactly in RUN.
REQ-019 SHALL ignore TRIGGER writes received in RUN, including in the same cycle as done_i.
REQ-020 SHALL ignore done_i in IDLE.
REQ-021 SHALL read STATUS as {31'b0, busy_o}, read TRIGGER as 0, and treat STATUS and JOB_CNT writes as no-ops.
REQ-022 SHALL increment the 32-bit JOB_CNT on each accepted done_i, wrapping 0xFFFFFFFF->0.
REQ-023 SHALL return 0 for unmapped reads and discard unmapped writes, without error signalling.

Reset
REQ-024 SHALL asynchronously reset to: state IDLE, all CFG, JOB_CNT and PERF_CYC registers 0; r_valid, r_data, r_id, start_o and evt_o 0.
REQ-025 SHALL, on reset during RUN, return to IDLE and SHALL NOT emit any pending response.

Configuration
REQ-026 SHALL compile the cycle counter in when SNAX_HWPE_PERF_CNT_EN is defined: PERF_CYC clears on entering RUN, increments each RUN cycle, saturates at 0xFFFFFFFF and holds after done_i.
REQ-027 SHALL, without SNAX_HWPE_PERF_CNT_EN, contain no counter logic; PERF_CYC reads 0.

Structure
REQ-028 SHALL place the register offsets, the FSM state enum and the ID width constant in shared package snax_hwpe_reg_pkg.
REQ-029 SHALL be a single module; sub-modules are optional, and the only natural one is snax_hwpe_job_fsm, which implements REQ-017 to REQ-020.

Verification
REQ-030 SHALL verify CFG access: write 0xA5A5A5A5 to 0x10 with be=0xF, then read 0x10 -> r_valid one cycle after each grant; read r_data=0xA5A5A5A5, cfg_o[0]=0xA5A5A5A5.
REQ-031 SHALL verify byte enables: write 0x11223344 to 0x14 with be=0x5 after reset -> read returns 0x00220044.
REQ-032 SHALL verify a job: write TRIGGER, hold 10 cycles, then pulse done_i -> start_o pulses once, busy_o high for the whole job, evt_o pulses, JOB_CNT=1, PERF_CYC=10 when the macro is defined, else 0.
REQ-033 SHALL verify RUN-phase blocking: in RUN, write 0xFFFFFFFF to CFG[0] and write TRIGGER -> CFG[0] unchanged, no second start_o, responses still returned with correct r_id.
REQ-034 SHALL verify the simultaneous case: TRIGGER write in the same cycle as done_i -> state IDLE afterwards, no start_o, JOB_CNT increments by 1.
REQ-035 SHALL verify wrap and back-to-back traffic: preload JOB_CNT to 0xFFFFFFFF via a test force, complete a job -> JOB_CNT=0; issue back-to-back reads with ids 3,4,5 -> r_id sequence 3,4,5 on consecutive cycles.
